// File: rtl/pipelined_dot_product_engine.sv
// Streaming signed dot-product engine: NI-element packages, NUM_MULT shared multipliers,
// registered adder tree and wide accumulator. Define DOT_PRODUCT_SATURATE_EN for a sticky saturating accumulator.
module pipelined_dot_product_engine #(
  parameter int element_width = 32,
  parameter int NI            = 8,
  parameter int NUM_MULT      = 4,
  parameter int LEN_WIDTH     = 8,
  parameter int ACC_WIDTH     = 72
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [LEN_WIDTH-1:0]            num_packages,
  input  logic [element_width*NI-1:0]     first_row_input,
  input  logic [element_width*NI-1:0]     second_row_input,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            busy,
  output logic signed [ACC_WIDTH-1:0]     dot_product_output,
  output logic                            finish
);

  localparam int P   = NI / NUM_MULT;
  localparam int PW  = 2 * element_width;
  localparam int TW  = PW + $clog2(NUM_MULT) + 1;
  localparam int SLW = (P > 1) ? $clog2(P) : 1;
  localparam int IW  = $clog2(NI);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SLICE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                      state_q, state_d;
  logic [LEN_WIDTH-1:0]            rem_q, rem_d;
  logic [SLW-1:0]                  slice_q, slice_d;
  logic                            drain_q, drain_d;
  logic                            load_pkg, clear_acc, last_slice, hs;
  logic signed [element_width-1:0] pkg_a_q [NI];
  logic signed [element_width-1:0] pkg_b_q [NI];
  logic [IW-1:0]                   idx;
  logic signed [PW-1:0]            prod_d  [NUM_MULT];
  logic signed [PW-1:0]            prod_p0 [NUM_MULT];
  logic                            vld_p0, vld_p1;
  logic signed [TW-1:0]            tree_d, tree_p1;
  logic signed [ACC_WIDTH-1:0]     acc_q, acc_d, dp_q;
  logic                            finish_q;

`ifdef DOT_PRODUCT_SATURATE_EN
  localparam int SW = ((ACC_WIDTH > TW) ? ACC_WIDTH : TW) + 1;
  logic                            sat_q, sat_d;
  logic signed [SW-1:0]            sum_w;

  function automatic logic acc_ovf(input logic signed [SW-1:0] x);
    logic [SW-ACC_WIDTH:0] hi;
    hi = x[SW-1:ACC_WIDTH-1];
    return !((&hi) || (~|hi));
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [SW-1:0] x);
    if (!acc_ovf(x))
      return x[ACC_WIDTH-1:0];
    else if (x[SW-1])
      return {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(ACC_WIDTH-1){1'b1}}};
  endfunction
`endif

  function automatic logic signed [PW-1:0] sext_el(input logic signed [element_width-1:0] x);
    return PW'(x);
  endfunction

  always_comb begin
    last_slice = (slice_q == SLW'(P - 1));
    in_ready   = (state_q == S_LOAD) ||
                 ((state_q == S_SLICE) && last_slice && (rem_q != '0));
    hs         = in_valid && in_ready;
    busy       = (state_q == S_LOAD) || (state_q == S_SLICE) || (state_q == S_DRAIN);
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    slice_d   = slice_q;
    drain_d   = drain_q;
    load_pkg  = 1'b0;
    clear_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d     = num_packages;
          clear_acc = 1'b1;
          state_d   = (num_packages == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (hs) begin
          load_pkg = 1'b1;
          slice_d  = '0;
          rem_d    = rem_q - LEN_WIDTH'(1);
          state_d  = S_SLICE;
        end
      end
      S_SLICE: begin
        if (!last_slice) begin
          slice_d = slice_q + SLW'(1);
        end else if (hs) begin
          load_pkg = 1'b1;
          slice_d  = '0;
          rem_d    = rem_q - LEN_WIDTH'(1);
        end else if (rem_q != '0) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      // Two DRAIN cycles plus DONE cover the product/tree/accumulator stages;
      // finish is registered out of DONE so it lines up with the loaded result.
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Slice s uses the most-significant elements first.
  always_comb begin
    idx = '0;
    for (int j = 0; j < NUM_MULT; j++) begin
      idx       = IW'(NI - 1 - int'(slice_q) * NUM_MULT - j);
      prod_d[j] = sext_el(pkg_a_q[idx]) * sext_el(pkg_b_q[idx]);
    end
  end

  always_comb begin
    tree_d = '0;
    for (int j = 0; j < NUM_MULT; j++)
      tree_d = tree_d + TW'(prod_p0[j]);
  end

`ifdef DOT_PRODUCT_SATURATE_EN
  always_comb begin
    sum_w = SW'(acc_q) + SW'(tree_p1);
    acc_d = sat_q ? acc_q : sat_acc(sum_w);
    sat_d = sat_q || acc_ovf(sum_w);
  end
`else
  always_comb acc_d = acc_q + ACC_WIDTH'(tree_p1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      slice_q  <= '0;
      drain_q  <= 1'b0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      tree_p1  <= '0;
      acc_q    <= '0;
      dp_q     <= '0;
      finish_q <= 1'b0;
      for (int i = 0; i < NI; i++) begin
        pkg_a_q[i] <= '0;
        pkg_b_q[i] <= '0;
      end
      for (int j = 0; j < NUM_MULT; j++) prod_p0[j] <= '0;
`ifdef DOT_PRODUCT_SATURATE_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      slice_q <= slice_d;
      drain_q <= drain_d;
      if (load_pkg) begin
        for (int i = 0; i < NI; i++) begin
          pkg_a_q[i] <= first_row_input[i*element_width +: element_width];
          pkg_b_q[i] <= second_row_input[i*element_width +: element_width];
        end
      end
      // p0: multipliers
      vld_p0  <= (state_q == S_SLICE);
      prod_p0 <= prod_d;
      // p1: adder tree
      vld_p1  <= vld_p0;
      tree_p1 <= tree_d;
      // p2: accumulator
      if (clear_acc) begin
        acc_q <= '0;
`ifdef DOT_PRODUCT_SATURATE_EN
        sat_q <= 1'b0;
`endif
      end else if (vld_p1) begin
        acc_q <= acc_d;
`ifdef DOT_PRODUCT_SATURATE_EN
        sat_q <= sat_d;
`endif
      end
      finish_q <= (state_q == S_DONE);
      if (state_q == S_DONE) dp_q <= acc_q;
    end
  end

  assign dot_product_output = dp_q;
  assign finish             = finish_q;

endmodule

// File: tb/tb_pipelined_dot_product_engine.sv
// Directed bench for pipelined_dot_product_engine: default 32-bit instance plus an
// 8-bit/16-bit instance for accumulator overflow behaviour.
module tb_pipelined_dot_product_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, start, in_valid;
  logic [7:0]         num_packages;
  logic [255:0]       first_row_input, second_row_input;
  logic               in_ready, busy, finish;
  logic signed [71:0] dot_product_output;

  logic               start_b, in_valid_b;
  logic [7:0]         num_b;
  logic [63:0]        first_b, second_b;
  logic               in_ready_b, busy_b, finish_b;
  logic signed [15:0] dp_b;

  pipelined_dot_product_engine dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .num_packages       (num_packages),
    .first_row_input    (first_row_input),
    .second_row_input   (second_row_input),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .busy               (busy),
    .dot_product_output (dot_product_output),
    .finish             (finish)
  );

  pipelined_dot_product_engine #(
    .element_width (8),
    .NI            (8),
    .NUM_MULT      (4),
    .LEN_WIDTH     (8),
    .ACC_WIDTH     (16)
  ) dut_b (
    .clk                (clk),
    .reset              (reset),
    .start              (start_b),
    .num_packages       (num_b),
    .first_row_input    (first_b),
    .second_row_input   (second_b),
    .in_valid           (in_valid_b),
    .in_ready           (in_ready_b),
    .busy               (busy_b),
    .dot_product_output (dp_b),
    .finish             (finish_b)
  );

  int           n_chk = 0;
  int           n_pass = 0;
  logic [255:0] pa [3];
  logic [255:0] pb [3];
  int           hs_cyc [3];
  int           n_hs, lat, rdy_mask;
  bit           timeout, busy_seen, rdy_late;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] fill(input int v);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [255:0] ramp();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = i + 1;
    return r;
  endfunction

  // Starts an operation, offers pa/pb packages with in_valid held high, then waits for finish.
  task automatic run_op(input int n);
    int cyc;
    timeout = 0; busy_seen = 0; rdy_late = 0; rdy_mask = 0; n_hs = 0; lat = 0;
    for (int i = 0; i < 3; i++) hs_cyc[i] = -1;
    start = 1'b1; num_packages = 8'(n);
    tick();
    start = 1'b0;
    busy_seen = busy;
    cyc = 0;
    while (n_hs < n && cyc < 40) begin
      first_row_input  = pa[n_hs];
      second_row_input = pb[n_hs];
      in_valid = 1'b1;
      if (in_ready) begin
        rdy_mask = rdy_mask | (1 << cyc);
        hs_cyc[n_hs] = cyc;
        n_hs++;
      end
      tick();
      busy_seen = busy_seen | busy;
      cyc++;
    end
    in_valid = 1'b0;
    if (n_hs < n) timeout = 1;
    while (!finish && lat < 40) begin
      tick();
      lat++;
      busy_seen = busy_seen | busy;
      rdy_late  = rdy_late | in_ready;
    end
    if (!finish) timeout = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_chk++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (finish !== 1'b0) $display("FAIL reset_finish: got %b want 0", finish); else n_pass++;
    n_chk++; if (dot_product_output !== 72'sd0) $display("FAIL reset_output: got %0d want 0", dot_product_output); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    pa[0] = ramp(); pb[0] = fill(1);
    run_op(1);
    n_chk++; if (timeout !== 1'b0) $display("FAIL basic_timeout: got %b want 0", timeout); else n_pass++;
    n_chk++; if (hs_cyc[0] != 0) $display("FAIL basic_load_ready: handshake cycle %0d want 0", hs_cyc[0]); else n_pass++;
    n_chk++; if (lat != 5) $display("FAIL basic_latency: got %0d edges want 5", lat); else n_pass++;
    n_chk++; if (rdy_late !== 1'b0) $display("FAIL basic_ready_in_slice: got %b want 0", rdy_late); else n_pass++;
    n_chk++; if (dot_product_output !== 72'sd36) $display("FAIL basic_result: got %0d want 36", dot_product_output); else n_pass++;
    tick();
    n_chk++; if (finish !== 1'b0) $display("FAIL basic_finish_pulse: got %b want 0", finish); else n_pass++;
    n_chk++; if (dot_product_output !== 72'sd36) $display("FAIL basic_hold: got %0d want 36", dot_product_output); else n_pass++;
  endtask

  task automatic test_back_to_back();
    pa[0] = fill(1); pa[1] = fill(2); pa[2] = fill(3);
    pb[0] = fill(1); pb[1] = fill(1); pb[2] = fill(1);
    run_op(3);
    n_chk++; if (timeout !== 1'b0) $display("FAIL b2b_timeout: got %b want 0", timeout); else n_pass++;
    n_chk++; if (rdy_mask != 21) $display("FAIL b2b_ready_pattern: got %b want 10101", rdy_mask); else n_pass++;
    n_chk++; if (lat != 5) $display("FAIL b2b_latency: got %0d edges want 5", lat); else n_pass++;
    n_chk++; if (dot_product_output !== 72'sd48) $display("FAIL b2b_result: got %0d want 48", dot_product_output); else n_pass++;
  endtask

  task automatic test_signed();
    pa[0] = fill(-3); pa[1] = fill(-3);
    pb[0] = fill(7);  pb[1] = fill(7);
    run_op(2);
    n_chk++; if (timeout !== 1'b0) $display("FAIL signed_timeout: got %b want 0", timeout); else n_pass++;
    n_chk++; if (lat != 5) $display("FAIL signed_latency: got %0d edges want 5", lat); else n_pass++;
    n_chk++; if (dot_product_output !== -72'sd336) $display("FAIL signed_result: got %0d want -336", dot_product_output); else n_pass++;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; num_packages = 8'd3;
    tick();
    start = 1'b0;
    first_row_input = fill(5); second_row_input = fill(9); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL midreset_in_ready: got %b want 0", in_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (dot_product_output !== 72'sd0) $display("FAIL midreset_output: got %0d want 0", dot_product_output); else n_pass++;
    tick();
    pa[0] = ramp(); pb[0] = fill(1);
    run_op(1);
    n_chk++; if (timeout !== 1'b0) $display("FAIL midreset_rerun_timeout: got %b want 0", timeout); else n_pass++;
    n_chk++; if (dot_product_output !== 72'sd36) $display("FAIL midreset_rerun_result: got %0d want 36", dot_product_output); else n_pass++;
  endtask

  task automatic test_empty();
    run_op(0);
    n_chk++; if (timeout !== 1'b0) $display("FAIL empty_timeout: got %b want 0", timeout); else n_pass++;
    n_chk++; if (lat != 1) $display("FAIL empty_latency: finish %0d edges after start edge, want 1", lat); else n_pass++;
    n_chk++; if (busy_seen !== 1'b0) $display("FAIL empty_busy: got %b want 0", busy_seen); else n_pass++;
    n_chk++; if (dot_product_output !== 72'sd0) $display("FAIL empty_result: got %0d want 0", dot_product_output); else n_pass++;
  endtask

  task automatic test_overflow();
    logic signed [15:0] want;
    int acc_cnt, cyc, wait_cnt;
`ifdef DOT_PRODUCT_SATURATE_EN
    want = 16'sh7FFF;
`else
    want = -16'sd6120;
`endif
    start_b = 1'b1; num_b = 8'd3;
    tick();
    start_b = 1'b0;
    first_b = 64'h7F7F_7F7F_7F7F_7F7F; second_b = 64'h7F7F_7F7F_7F7F_7F7F;
    in_valid_b = 1'b1;
    acc_cnt = 0; cyc = 0;
    while (acc_cnt < 3 && cyc < 40) begin
      if (in_ready_b) acc_cnt++;
      tick();
      cyc++;
    end
    in_valid_b = 1'b0;
    wait_cnt = 0;
    while (!finish_b && wait_cnt < 40) begin
      tick();
      wait_cnt++;
    end
    n_chk++; if (finish_b !== 1'b1) $display("FAIL overflow_timeout: finish=%b want 1", finish_b); else n_pass++;
    n_chk++; if (dp_b !== want) $display("FAIL overflow_result: got %0d want %0d", dp_b, want); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; num_packages = '0;
    first_row_input = '0; second_row_input = '0;
    start_b = 1'b0; in_valid_b = 1'b0; num_b = '0; first_b = '0; second_b = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_signed();
    test_reset_mid();
    test_empty();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
